// File: rtl/washer_pkg.sv
// ---------------------------------------------------------------------------
// washer_pkg
// Shared types and constants for the station washer sequencer.
//   - washState_t : sequencer state encoding
//   - TMR_W       : width of the phase timer (cycles per phase up to 65535)
//   - STROKE_W    : width of the stroke counter (up to 255 strokes)
//   - DEF_*       : default phase lengths for a 50 kHz MCLK
// ---------------------------------------------------------------------------
package washer_pkg;

    localparam int TMR_W    = 16;
    localparam int STROKE_W = 8;

    // 0.5 s electromagnet settle, 0.5 s per servo position, 0.25 s release
    localparam int DEF_EM_SETTLE    = 25000;
    localparam int DEF_SERVO_HOLD   = 25000;
    localparam int DEF_NUM_STROKES  = 4;
    localparam int DEF_RELEASE_WAIT = 12500;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EM_ON,
        S_SCRUB_HI,
        S_SCRUB_LO,
        S_RELEASE,
        S_DONE
    } washState_t;

endpackage

// File: rtl/washer_timer.sv
// ---------------------------------------------------------------------------
// washer_timer
// Loadable down-counter that times each sequencer phase. Loading N-1 on
// phase entry and leaving the phase on the edge where the count reads zero
// gives a phase of exactly N cycles. The count parks at zero once expired.
// Ports:
//   clk_i      : system clock
//   rst_i      : asynchronous active-high reset, clears the count
//   load_i     : load loadVal_i on the next edge (takes priority over count)
//   loadVal_i  : value to load (phase length minus one)
//   value_o    : current count
//   zero_o     : count is zero, phase ends on this edge
// ---------------------------------------------------------------------------
module washer_timer
    import washer_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [TMR_W-1:0] loadVal_i,
    output logic [TMR_W-1:0] value_o,
    output logic             zero_o
);

    logic [TMR_W-1:0] count_q;

    // Load wins over counting; otherwise count down and hold at zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= loadVal_i;
        end else if (count_q != '0) begin
            count_q <= count_q - TMR_W'(1);
        end
    end

    assign value_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/washer_sequencer.sv
// ---------------------------------------------------------------------------
// washer_sequencer
// Runs one wash per request: electromagnet on, NUM_STROKES servo strokes,
// electromagnet off, wait, then a one-cycle done pulse. An abort during the
// powered phases skips straight to the release wait, which is always served
// in full so the part is never dropped early.
// Ports:
//   MCLK         : system clock (50 kHz)
//   RST          : asynchronous active-high reset, drops everything at once
//   startWash    : wash request, honoured only in IDLE and only without abort
//   abortWash    : abort request, honoured in EM_ON / SCRUB_HI / SCRUB_LO
//   controlServo : servo position select to WasherPWM (high in SCRUB_HI)
//   powerEM      : electromagnet enable
//   busy         : wash in progress (EM_ON through RELEASE)
//   done         : one-cycle completion pulse
//   aborted      : with done, the wash ended early
// ---------------------------------------------------------------------------
module washer_sequencer
    import washer_pkg::*;
#(
    parameter int EM_SETTLE    = DEF_EM_SETTLE,
    parameter int SERVO_HOLD   = DEF_SERVO_HOLD,
    parameter int NUM_STROKES  = DEF_NUM_STROKES,
    parameter int RELEASE_WAIT = DEF_RELEASE_WAIT
) (
    input  logic MCLK,
    input  logic RST,
    input  logic startWash,
    input  logic abortWash,
    output logic controlServo,
    output logic powerEM,
    output logic busy,
    output logic done,
    output logic aborted
);

    washState_t          state_q, state_d;
    logic [STROKE_W-1:0] stroke_q, stroke_d;
    logic                aborted_q, aborted_d;

    logic                servo_q, em_q, busy_q, done_q;

    logic                tmrLoad;
    logic [TMR_W-1:0]    tmrLoadVal;
    logic [TMR_W-1:0]    tmrValue;
    logic                tmrZero;
    logic                unusedTmrValue;

    washer_timer u_timer (
        .clk_i     (MCLK),
        .rst_i     (RST),
        .load_i    (tmrLoad),
        .loadVal_i (tmrLoadVal),
        .value_o   (tmrValue),
        .zero_o    (tmrZero)
    );

    // Only the zero flag steers the sequence; the raw count is for debug taps.
    assign unusedTmrValue = ^tmrValue;

    // Next-state logic. Abort takes priority over phase expiry in the powered
    // phases. The timer is reloaded on every state change with the length of
    // the phase being entered, so each timed phase lasts exactly its count.
    always_comb begin
        state_d    = state_q;
        stroke_d   = stroke_q;
        aborted_d  = aborted_q;
        tmrLoad    = 1'b0;
        tmrLoadVal = '0;

        case (state_q)
            S_IDLE: begin
                if (startWash && !abortWash) begin
                    state_d = S_EM_ON;
                end
            end
            S_EM_ON: begin
                if (abortWash) begin
                    state_d   = S_RELEASE;
                    aborted_d = 1'b1;
                end else if (tmrZero) begin
                    state_d = S_SCRUB_HI;
                end
            end
            S_SCRUB_HI: begin
                if (abortWash) begin
                    state_d   = S_RELEASE;
                    aborted_d = 1'b1;
                end else if (tmrZero) begin
                    state_d = S_SCRUB_LO;
                end
            end
            S_SCRUB_LO: begin
                if (abortWash) begin
                    state_d   = S_RELEASE;
                    aborted_d = 1'b1;
                end else if (tmrZero) begin
                    // A stroke completes at the end of the low half.
                    stroke_d = stroke_q + STROKE_W'(1);
                    if (stroke_d == STROKE_W'(NUM_STROKES)) begin
                        state_d = S_RELEASE;
                    end else begin
                        state_d = S_SCRUB_HI;
                    end
                end
            end
            S_RELEASE: begin
                if (tmrZero) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                stroke_d  = '0;
                aborted_d = 1'b0;
            end
            default: begin
                state_d   = S_IDLE;
                stroke_d  = '0;
                aborted_d = 1'b0;
            end
        endcase

        if (state_d != state_q) begin
            tmrLoad = 1'b1;
            case (state_d)
                S_EM_ON:    tmrLoadVal = TMR_W'(EM_SETTLE - 1);
                S_SCRUB_HI: tmrLoadVal = TMR_W'(SERVO_HOLD - 1);
                S_SCRUB_LO: tmrLoadVal = TMR_W'(SERVO_HOLD - 1);
                S_RELEASE:  tmrLoadVal = TMR_W'(RELEASE_WAIT - 1);
                default:    tmrLoadVal = '0;
            endcase
        end
    end

    // State register plus outputs decoded from the next state, so every
    // output changes on the same edge as the state and never glitches.
    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            stroke_q  <= '0;
            aborted_q <= 1'b0;
            servo_q   <= 1'b0;
            em_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            stroke_q  <= stroke_d;
            aborted_q <= aborted_d;
            servo_q   <= (state_d == S_SCRUB_HI);
            em_q      <= (state_d inside {S_EM_ON, S_SCRUB_HI, S_SCRUB_LO});
            busy_q    <= (state_d inside {S_EM_ON, S_SCRUB_HI, S_SCRUB_LO, S_RELEASE});
            done_q    <= (state_d == S_DONE);
        end
    end

    assign controlServo = servo_q;
    assign powerEM      = em_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign aborted      = aborted_q;

endmodule

// File: tb/tb_washer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_washer_sequencer
// Self-checking bench for washer_sequencer with short phase lengths.
// The reference describes a wash as a timeline: the edge its start was
// sampled on and, optionally, the edge an abort was sampled on. Expected
// outputs for any cycle follow from that with plain arithmetic.
// Cycle n is the clock period that follows edge n-1.
// ---------------------------------------------------------------------------
module tb_washer_sequencer;

    localparam int EM = 4;
    localparam int SH = 3;
    localparam int NS = 2;
    localparam int RW = 5;
    localparam int P  = EM + 2 * SH * NS;

    logic MCLK;
    logic RST;
    logic startWash;
    logic abortWash;
    logic controlServo;
    logic powerEM;
    logic busy;
    logic done;
    logic aborted;

    int errors = 0;
    int checks = 0;

    int cycleNo = 0;
    int wStart  = -1;
    int wAbort  = -1;
    int lastDone    = -1;
    logic lastAbort = 1'b0;
    int sCyc;

    washer_sequencer #(
        .EM_SETTLE    (EM),
        .SERVO_HOLD   (SH),
        .NUM_STROKES  (NS),
        .RELEASE_WAIT (RW)
    ) dut (
        .MCLK         (MCLK),
        .RST          (RST),
        .startWash    (startWash),
        .abortWash    (abortWash),
        .controlServo (controlServo),
        .powerEM      (powerEM),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted)
    );

    // 10-unit clock period
    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    // Last cycle of the powered phase of the current wash
    function automatic int endPow();
        return (wAbort >= 0) ? wAbort : wStart + P;
    endfunction

    // Cycle holding the done pulse of the current wash
    function automatic int doneCyc();
        return endPow() + RW + 1;
    endfunction

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic checkInt(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compare all outputs against the timeline for the current cycle
    task automatic checkOutput(input string tag);
        logic eServo, eEm, eBusy, eDone, eAb;
        int   u;
        eServo = 1'b0; eEm = 1'b0; eBusy = 1'b0; eDone = 1'b0; eAb = 1'b0;
        if (wStart >= 0 && cycleNo > wStart) begin
            if (cycleNo <= endPow()) begin
                eEm   = 1'b1;
                eBusy = 1'b1;
                u = cycleNo - wStart - EM - 1;
                if (u >= 0) eServo = ((u / SH) % 2 == 0);
            end else if (cycleNo < doneCyc()) begin
                eBusy = 1'b1;
                eAb   = (wAbort >= 0);
            end else if (cycleNo == doneCyc()) begin
                eDone = 1'b1;
                eAb   = (wAbort >= 0);
            end
        end
        checkBit({tag, ".controlServo"}, controlServo, eServo);
        checkBit({tag, ".powerEM"}, powerEM, eEm);
        checkBit({tag, ".busy"}, busy, eBusy);
        checkBit({tag, ".done"}, done, eDone);
        checkBit({tag, ".aborted"}, aborted, eAb);
        if (done === 1'b1) begin
            lastDone  = cycleNo;
            lastAbort = aborted;
        end
    endtask

    // Drive one cycle of inputs, advance the timeline at the edge, then check
    task automatic applyStimulus(input logic s, input logic a, input string tag);
        startWash = s;
        abortWash = a;
        @(posedge MCLK);
        if (wStart < 0 || cycleNo > doneCyc()) begin
            if (s && !a) begin
                wStart = cycleNo;
                wAbort = -1;
            end else begin
                wStart = -1;
            end
        end else if (a && cycleNo > wStart && cycleNo <= endPow()) begin
            wAbort = cycleNo;
        end
        cycleNo++;
        #1;
        checkOutput(tag);
    endtask

    initial begin
        RST       = 1'b1;
        startWash = 1'b0;
        abortWash = 1'b0;

        // Reset state
        repeat (2) @(posedge MCLK);
        #1;
        checkOutput("reset");
        #2 RST = 1'b0;

        // Nominal wash
        lastDone = -1;
        sCyc = cycleNo;
        applyStimulus(1'b1, 1'b0, "nominal");
        for (int i = 1; i <= 23; i++) applyStimulus(1'b0, 1'b0, "nominal");
        checkInt("nominal.doneCycle", lastDone - sCyc, 22);
        checkBit("nominal.abortedAtDone", lastAbort, 1'b0);

        // Abort during SCRUB_LO
        lastDone = -1;
        sCyc = cycleNo;
        applyStimulus(1'b1, 1'b0, "abortLo");
        for (int i = 1; i <= 16; i++) applyStimulus(1'b0, i == 9, "abortLo");
        checkInt("abortLo.doneCycle", lastDone - sCyc, 15);
        checkBit("abortLo.abortedAtDone", lastAbort, 1'b1);

        // Abort during RELEASE is ignored
        lastDone = -1;
        sCyc = cycleNo;
        applyStimulus(1'b1, 1'b0, "abortRel");
        for (int i = 1; i <= 23; i++) applyStimulus(1'b0, i == 18, "abortRel");
        checkInt("abortRel.doneCycle", lastDone - sCyc, 22);
        checkBit("abortRel.abortedAtDone", lastAbort, 1'b0);

        // Start together with abort in IDLE does nothing
        applyStimulus(1'b1, 1'b1, "startAbortIdle");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, "startAbortIdle");

        // Start re-pulsed mid-wash has no effect on timing
        lastDone = -1;
        sCyc = cycleNo;
        applyStimulus(1'b1, 1'b0, "restartMid");
        for (int i = 1; i <= 23; i++) applyStimulus(i == 10, 1'b0, "restartMid");
        checkInt("restartMid.doneCycle", lastDone - sCyc, 22);

        // Asynchronous reset in cycle 12, then a full wash
        applyStimulus(1'b1, 1'b0, "midReset");
        for (int i = 1; i <= 11; i++) applyStimulus(1'b0, 1'b0, "midReset");
        #2 RST = 1'b1;
        wStart = -1;
        #1;
        checkOutput("midReset.async");
        #2 RST = 1'b0;
        lastDone = -1;
        sCyc = cycleNo;
        applyStimulus(1'b1, 1'b0, "afterReset");
        for (int i = 1; i <= 23; i++) applyStimulus(1'b0, 1'b0, "afterReset");
        checkInt("afterReset.doneCycle", lastDone - sCyc, 22);

        // Start held high: back-to-back washes
        lastDone = -1;
        sCyc = cycleNo;
        for (int i = 0; i <= 30; i++) applyStimulus(1'b1, 1'b0, "heldStart");
        checkInt("heldStart.firstDone", lastDone - sCyc, 22);
        for (int i = 0; i < 25; i++) applyStimulus(1'b0, 1'b0, "heldStart");
        checkInt("heldStart.secondDone", lastDone - sCyc, 45);

        // Random start/abort traffic against the timeline reference
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
